// File: rtl/fetch_if.sv
// fetch_if: imem request/response, execute redirect and decode handshake bundle for fetch_unit
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc;
  logic [31:0] d_insn;
  logic        fetch_fault;
  modport master (
    output imem_req, imem_addr, d_valid, d_pc, d_insn, fetch_fault,
    input  imem_rdata, redirect_valid, redirect_pc, d_ready
  );
  modport slave (
    input  imem_req, imem_addr, d_valid, d_pc, d_insn, fetch_fault,
    output imem_rdata, redirect_valid, redirect_pc, d_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing 1-cycle imem reads into a BUF_DEPTH {pc,insn} FIFO for decode, with redirect flush and misaligned-target fault (ports: clk, rst, bus=fetch_if.master)
module fetch_unit #(
  parameter logic [31:0] START_ADDR = 32'h01000000,
  parameter int          BUF_DEPTH  = 2
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic [31:0]   hold_pc_q, hold_pc_d, hold_insn_q, hold_insn_d;
  logic          inflight_q, inflight_d, fault_q, fault_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [63:0]   buf_q [BUF_DEPTH];
  logic [63:0]   buf_d [BUF_DEPTH];
  logic [CW:0]   level;
  logic [63:0]   head_e;
  logic          redir, aligned, nonempty, pop, push, issue;
  always_comb begin
    redir = bus.redirect_valid;
    aligned = bus.redirect_pc[1:0] == 2'b00;
    nonempty = occ_q != '0;
    head_e = buf_q[head_q];
    bus.d_valid = nonempty && !redir && !rst;
    pop = bus.d_valid && bus.d_ready;
    push = inflight_q && !redir;
    level = {1'b0, occ_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue = !rst && !fault_q && !redir && level < (CW+1)'(BUF_DEPTH);
    bus.imem_req = issue;
    bus.imem_addr = fetch_pc_q;
    bus.d_pc = nonempty ? head_e[63:32] : hold_pc_q;
    bus.d_insn = nonempty ? head_e[31:0] : hold_insn_q;
    bus.fetch_fault = fault_q;
    fetch_pc_d = redir ? (aligned ? bus.redirect_pc : fetch_pc_q) : (issue ? fetch_pc_q + 32'd4 : fetch_pc_q);
    fault_d = redir ? !aligned : fault_q;
    inflight_d = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
    head_d = redir ? '0 : head_q + AW'(pop);
    tail_d = redir ? '0 : tail_q + AW'(push);
    occ_d = redir ? '0 : occ_q + CW'(push) - CW'(pop);
    hold_pc_d = bus.d_pc;
    hold_insn_d = bus.d_insn;
    buf_d = buf_q;
    buf_d[tail_q] = push ? {inflight_pc_q, bus.imem_rdata} : buf_q[tail_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= START_ADDR;
      inflight_pc_q <= '0;
      hold_pc_q <= '0;
      hold_insn_q <= '0;
      inflight_q <= 1'b0;
      fault_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      occ_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      hold_pc_q <= hold_pc_d;
      hold_insn_q <= hold_insn_d;
      inflight_q <= inflight_d;
      fault_q <= fault_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk) buf_q <= buf_d;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a queue-based fetch model
module tb_fetch_unit;
  localparam logic [31:0] START = 32'h01000000;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_if ifc();
  fetch_unit #(.START_ADDR(START), .BUF_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(ifc));
  function automatic logic [31:0] ins(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13572468;
  endfunction
  always @(posedge clk) ifc.imem_rdata <= ifc.imem_req ? ins(ifc.imem_addr) : $urandom;
  int total = 0;
  int bad = 0;
  logic [63:0] q[$];
  bit          infl, flt, known;
  logic [31:0] infl_pc, fpc, last_pc, last_insn;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit ev, er, p;
    logic [31:0] ep, ei;
    @(negedge clk);
    rst = r;
    ifc.redirect_valid = rv;
    ifc.redirect_pc = rpc;
    ifc.d_ready = rdy;
    #1;
    ev = !r && q.size() != 0 && !rv;
    ep = q.size() != 0 ? q[0][63:32] : last_pc;
    ei = q.size() != 0 ? q[0][31:0] : last_insn;
    p = ev && rdy;
    er = !r && !flt && !rv && (q.size() + int'(infl) - int'(p)) < DEPTH;
    if (known) begin
      chk("d_valid", 32'(ifc.d_valid), 32'(ev));
      chk("imem_req", 32'(ifc.imem_req), 32'(er));
      chk("imem_addr", ifc.imem_addr, fpc);
      chk("d_pc", ifc.d_pc, ep);
      chk("d_insn", ifc.d_insn, ei);
      chk("fetch_fault", 32'(ifc.fetch_fault), 32'(flt));
    end
    last_pc = ep;
    last_insn = ei;
    if (r) begin
      q.delete();
      infl = 0;
      flt = 0;
      fpc = START;
      last_pc = 0;
      last_insn = 0;
      known = 1;
    end else if (rv) begin
      q.delete();
      infl = 0;
      if (rpc[1:0] == 2'b00) begin
        fpc = rpc;
        flt = 0;
      end else flt = 1;
    end else begin
      if (p) void'(q.pop_front());
      if (infl) q.push_back({infl_pc, ins(infl_pc)});
      infl = er;
      if (er) begin
        infl_pc = fpc;
        fpc = fpc + 32'd4;
      end
    end
  endtask
  initial begin
    known = 0;
    infl = 0;
    flt = 0;
    fpc = START;
    infl_pc = 0;
    last_pc = 0;
    last_insn = 0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;
    ifc.d_ready = 1'b0;
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("rst_d_pc", ifc.d_pc, 32'h0);
    chk("rst_d_insn", ifc.d_insn, 32'h0);
    chk("rst_addr", ifc.imem_addr, 32'h01000000);
    chk("rst_req", 32'(ifc.imem_req), 32'h0);
    step(0, 0, 0, 1);
    chk("t0_req", 32'(ifc.imem_req), 32'h1);
    chk("t0_addr", ifc.imem_addr, 32'h01000000);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("seq0_valid", 32'(ifc.d_valid), 32'h1);
    chk("seq0", ifc.d_pc, 32'h01000000);
    chk("seq0_insn", ifc.d_insn, 32'h0000FEFF ^ 32'h13572468);
    step(0, 0, 0, 1);
    chk("seq1", ifc.d_pc, 32'h01000004);
    step(0, 0, 0, 1);
    chk("seq2", ifc.d_pc, 32'h01000008);
    step(0, 0, 0, 1);
    chk("seq3", ifc.d_pc, 32'h0100000C);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("stall_req", 32'(ifc.imem_req), 32'h0);
    chk("stall_pc", ifc.d_pc, 32'h01000000);
    step(0, 0, 0, 1);
    chk("rel0", ifc.d_pc, 32'h01000000);
    step(0, 0, 0, 1);
    chk("rel1", ifc.d_pc, 32'h01000004);
    step(0, 0, 0, 1);
    chk("rel2", ifc.d_pc, 32'h01000008);
    step(0, 1, 32'h01000100, 1);
    chk("redir_valid", 32'(ifc.d_valid), 32'h0);
    step(0, 0, 0, 1);
    chk("redir_addr", ifc.imem_addr, 32'h01000100);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("redir_pc", ifc.d_pc, 32'h01000100);
    step(0, 1, 32'h01000102, 1);
    step(0, 0, 0, 1);
    chk("fault", 32'(ifc.fetch_fault), 32'h1);
    step(0, 0, 0, 1);
    chk("fault_req", 32'(ifc.imem_req), 32'h0);
    step(0, 1, 32'h01000200, 1);
    step(0, 0, 0, 1);
    chk("unfault", 32'(ifc.fetch_fault), 32'h0);
    chk("resume_addr", ifc.imem_addr, 32'h01000200);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("resume_pc", ifc.d_pc, 32'h01000200);
    step(0, 1, 32'hFFFFFFF8, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("wrap0", ifc.d_pc, 32'hFFFFFFF8);
    step(0, 0, 0, 1);
    chk("wrap1", ifc.d_pc, 32'hFFFFFFFC);
    step(0, 0, 0, 1);
    chk("wrap2", ifc.d_pc, 32'h00000000);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("mid_rst_valid", 32'(ifc.d_valid), 32'h0);
    chk("mid_rst_pc", ifc.d_pc, 32'h0);
    chk("mid_rst_addr", ifc.imem_addr, 32'h01000000);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 1) == 0) ? (START + ($urandom_range(0, 255) << 2)) : (32'hFFFFFF00 + ($urandom_range(0, 63) << 2));
      if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, t, $urandom_range(0, 3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
